cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares one sram-like memory port between the I-cache and the D-cache miss/write-back ports.
- Sits between both caches and the sram-to-AXI bridge.
- Allows one outstanding transaction at a time. D-cache has priority, with a bounded-starvation guard for the I-cache.
- Routes the handshake (addr_ok/data_ok) and read data back to the granted cache only.

Parameters:
MAX_D_STREAK, 4, consecutive contested D grants allowed before I wins the next conflict; 0 = strict D priority, guard disabled
STREAK_W, 3, width of the streak counter; must satisfy 2^STREAK_W > MAX_D_STREAK

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  I-cache request, held until i_addr_ok
i_wr  in  1  I-cache write flag
i_size  in  2  I-cache access size
i_addr  in  32  I-cache address
i_wdata  in  32  I-cache write data
i_rdata  out  32  read data to I-cache
i_addr_ok  out  1  I-cache address accepted
i_data_ok  out  1  I-cache transaction done
d_req, d_wr, d_size, d_addr, d_wdata  in  1/1/2/32/32  D-cache request set, same rules as I
d_rdata  out  32  read data to D-cache
d_addr_ok  out  1  D-cache address accepted
d_data_ok  out  1  D-cache transaction done
m_req  out  1  memory request
m_wr  out  1  memory write flag
m_size  out  2  memory access size
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data
m_addr_ok  in  1  memory address accepted
m_data_ok  in  1  memory transaction done

Behaviour:
- Protocol: sram-like. A request is accepted in the cycle where req & addr_ok. data_ok arrives one or more cycles after acceptance. At most one outstanding transaction.
- States: IDLE, AR_I, AR_D (address phase locked), DW_I, DW_D (waiting for data_ok). Encoding is free. State register clears asynchronously to IDLE when rst=0.
- IDLE grant (combinational, same cycle):
  - Only d_req -> D. Only i_req -> I.
  - Both asserted -> D, unless MAX_D_STREAK!=0 and streak==MAX_D_STREAK, then I.
  - m_req=1 in the grant cycle, and m_wr/m_size/m_addr/m_wdata are taken from the granted master.
- IDLE transitions: grant with m_addr_ok=1 -> DW_x. Grant with m_addr_ok=0 -> AR_x. No request -> stay IDLE, m_req=0.
- AR_x:
  - m_req=x_req; m_* muxed from x only.
  - The other master's request is ignored and its addr_ok stays 0.
  - m_addr_ok -> DW_x.
  - If x drops req before addr_ok (protocol violation), return to IDLE with no transaction issued.
- DW_x:
  - m_req=0.
  - On m_data_ok: x_data_ok=1 for that cycle, then -> IDLE.
  - A new grant is possible in the next cycle, not in the data_ok cycle (no back-to-back overlap).
- Handshake routing: x_addr_ok = m_addr_ok & (granted==x) & (state in IDLE-grant or AR_x). x_data_ok = m_data_ok & state==DW_x. The non-granted master's addr_ok/data_ok are always 0. A stray m_data_ok outside DW_x is ignored.
- Read data: i_rdata = d_rdata = m_rdata (unconditional); validity is qualified by data_ok.
- Streak counter (STREAK_W bits, async reset to 0):
  - Increments on a D acceptance (m_addr_ok) while i_req=1 in that cycle, saturating at MAX_D_STREAK.
  - Clears on any I acceptance.
  - Unchanged on a D acceptance while i_req=0.
- Idle output: when no grant is active, m_wr/m_size/m_addr/m_wdata are driven from the D-side inputs. Their values do not matter while m_req=0.
- Reset values: m_req=0, i_addr_ok=0, i_data_ok=0, d_addr_ok=0, d_data_ok=0, state=IDLE, streak=0.
- Reset mid-transaction: the in-flight transaction is abandoned and no data_ok is forwarded. The memory bridge is reset by the same rst.
- No combinational path from m_data_ok to m_req.
- m_addr_ok -> x_addr_ok is combinational.

Test Plan:
- Reset mid-DW_D: rst=0 while waiting for data_ok -> all ok outputs 0 and m_req=0 immediately (asynchronous). After release, an i_req is granted in the first cycle.
- Single I read: i_req=1, i_addr=0xBFC00000; m_addr_ok in the same cycle; m_data_ok 3 cycles later with m_rdata=0x3C080001 -> i_addr_ok pulses once, i_data_ok pulses once with i_rdata=0x3C080001, and d_* ok outputs stay 0 throughout.
- Simultaneous request: i_req=d_req=1 from reset -> D granted first (m_addr=d_addr=0x80001000, m_wr=1, m_wdata=0xDEADBEEF). I is granted in the cycle after d_data_ok.
- Starvation guard (MAX_D_STREAK=4): both requests held continuously -> grant order D,D,D,D,I,D,D,D,D,I. Streak reads 0 after each I acceptance.
- Address-phase lock: d_req in IDLE with m_addr_ok=0 for 5 cycles, i_req rising in cycle 2 -> m_addr stays the D address for all 5 cycles, and i_addr_ok=0 until D completes.
- Stray and late handshakes: m_data_ok pulsed in IDLE -> no x_data_ok. With MAX_D_STREAK=0 and both requests held, I is never granted while d_req stays 1.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one sram-like memory port between I-cache and D-cache, D-priority with I starvation guard
module cache_mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);
  typedef enum logic [2:0] {IDLE, AR_I, AR_D, DW_I, DW_D} state_t;
  state_t state, state_nxt;
  logic [STREAK_W-1:0] streak;
  logic at_max, force_i, sel_i;
  assign at_max = streak == STREAK_W'(MAX_D_STREAK);
  assign force_i = (MAX_D_STREAK != 0) && at_max;
  // state register, cleared asynchronously so an in-flight transaction is abandoned
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // next state: one outstanding transaction, address phase locked to the granted master
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_req | d_req) state_nxt = sel_i ? (m_addr_ok ? DW_I : AR_I) : (m_addr_ok ? DW_D : AR_D);
      AR_I: state_nxt = !i_req ? IDLE : m_addr_ok ? DW_I : AR_I;
      AR_D: state_nxt = !d_req ? IDLE : m_addr_ok ? DW_D : AR_D;
      DW_I, DW_D: state_nxt = m_data_ok ? IDLE : state;
      default: state_nxt = IDLE;
    endcase
  end
  // outputs: grant mux, handshake routing to the granted master only; m_req is forced low during reset
  always_comb begin
    sel_i = (state == AR_I) | (state == DW_I) | ((state == IDLE) & i_req & (~d_req | force_i));
    m_req = rst & ((state == IDLE) ? (i_req | d_req) : (state == AR_I) ? i_req : (state == AR_D) ? d_req : 1'b0);
    m_wr = sel_i ? i_wr : d_wr;
    m_size = sel_i ? i_size : d_size;
    m_addr = sel_i ? i_addr : d_addr;
    m_wdata = sel_i ? i_wdata : d_wdata;
    i_addr_ok = m_addr_ok & m_req & sel_i;
    d_addr_ok = m_addr_ok & m_req & ~sel_i;
    i_data_ok = m_data_ok & (state == DW_I);
    d_data_ok = m_data_ok & (state == DW_D);
    i_rdata = m_rdata;
    d_rdata = m_rdata;
  end
  // streak of D wins over a waiting I; saturates at the limit and clears on any I acceptance
  always_ff @(posedge clk or negedge rst)
    if (!rst) streak <= '0;
    else if (i_addr_ok) streak <= '0;
    else if (d_addr_ok && i_req && !at_max) streak <= streak + 1'b1;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: vector table plus scoreboarded sequences for cache_mem_arbiter
module tb_cache_mem_arbiter;
  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1000;
  logic clk = 0, rst = 0;
  logic i_req = 0, i_wr = 0, d_req = 0, d_wr = 0, m_addr_ok = 0, m_data_ok = 0;
  logic [1:0] i_size = 2'd1, d_size = 2'd2;
  logic [31:0] i_addr = IA, i_wdata = 32'h0, d_addr = DA, d_wdata = 32'h0, m_rdata = 32'h0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_req, m_wr;
  logic [1:0] m_size;
  logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0;
  logic i_addr_ok0, i_data_ok0, d_addr_ok0, d_data_ok0, m_req0, m_wr0;
  logic [1:0] m_size0;
  always #5 clk = ~clk;

  cache_mem_arbiter #(.MAX_D_STREAK(4), .STREAK_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok));

  cache_mem_arbiter #(.MAX_D_STREAK(0), .STREAK_W(3)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(1'b1), .i_wr(1'b0), .i_size(2'd2), .i_addr(IA), .i_wdata(32'h0),
    .i_rdata(i_rdata0), .i_addr_ok(i_addr_ok0), .i_data_ok(i_data_ok0),
    .d_req(1'b1), .d_wr(1'b0), .d_size(2'd2), .d_addr(DA), .d_wdata(32'h0),
    .d_rdata(d_rdata0), .d_addr_ok(d_addr_ok0), .d_data_ok(d_data_ok0),
    .m_req(m_req0), .m_wr(m_wr0), .m_size(m_size0), .m_addr(m_addr0), .m_wdata(m_wdata0),
    .m_rdata(m_rdata), .m_addr_ok(1'b1), .m_data_ok(1'b1));

  typedef struct {logic is_i; logic [31:0] data;} exp_t;
  typedef struct {logic ir; logic dr; logic aok; logic e_req; logic [31:0] e_addr; logic e_iaok; logic e_daok;} vec_t;
  exp_t sb[$];
  logic gq[$];
  vec_t tbl[8];
  int vectors = 0, miscompares = 0;
  int cnt_iaok = 0, cnt_daok = 0, cnt_idok = 0, cnt_ddok = 0, cnt_i0 = 0, cnt_d0 = 0;
  int lat = 2, cnt = 0, n_resp = 0;
  logic auto_mem = 0, acc = 0, chk_streak = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      if (chk_streak) check("streak_clear", 32'(dut.streak), 32'd0);
      chk_streak = i_addr_ok;
      cnt_iaok += 32'(i_addr_ok);
      cnt_daok += 32'(d_addr_ok);
      cnt_idok += 32'(i_data_ok);
      cnt_ddok += 32'(d_data_ok);
      cnt_i0 += 32'(i_addr_ok0);
      cnt_d0 += 32'(d_addr_ok0);
      if ((i_addr_ok | d_addr_ok) && gq.size() != 0) check("grant_order_is_i", 32'(i_addr_ok), 32'(gq.pop_front()));
      if (i_data_ok | d_data_ok) begin
        if (sb.size() == 0) check("sb_unexpected_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
        else begin
          e = sb.pop_front();
          check("data_ok_is_i", 32'({i_data_ok, d_data_ok}), e.is_i ? 32'd2 : 32'd1);
          check("rdata", e.is_i ? i_rdata : d_rdata, e.data);
        end
      end
    end
    acc = m_req & m_addr_ok;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      m_data_ok = 0;
      if (acc) cnt = lat;
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          m_data_ok = 1;
          m_rdata = 32'h1000_0000 + 32'(n_resp);
          n_resp++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 0;
    {i_req, d_req, i_wr, d_wr, m_addr_ok, m_data_ok, auto_mem, chk_streak} = '0;
    cnt = 0;
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    int c0, c1, c2;
    tbl[0] = '{0, 0, 0, 0, DA, 0, 0};
    tbl[1] = '{1, 0, 0, 1, IA, 0, 0};
    tbl[2] = '{0, 1, 0, 1, DA, 0, 0};
    tbl[3] = '{1, 1, 0, 1, DA, 0, 0};
    tbl[4] = '{1, 0, 1, 1, IA, 1, 0};
    tbl[5] = '{0, 1, 1, 1, DA, 0, 1};
    tbl[6] = '{0, 0, 1, 0, DA, 0, 0};
    tbl[7] = '{1, 1, 1, 1, DA, 0, 1};
    #1;
    check("reset_outputs", 32'({m_req, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 32'd0);
    do_reset();
    // combinational IDLE grant table; each vector is unwound by dropping requests next cycle
    for (int k = 0; k < 8; k++) begin
      i_req = tbl[k].ir; d_req = tbl[k].dr; m_addr_ok = tbl[k].aok; m_data_ok = 0;
      if (tbl[k].aok && (tbl[k].ir | tbl[k].dr)) sb.push_back('{tbl[k].e_iaok, 32'hA000_0000 + 32'(k)});
      #1;
      check("tbl_m_req", 32'(m_req), 32'(tbl[k].e_req));
      check("tbl_m_addr", m_addr, tbl[k].e_addr);
      check("tbl_i_addr_ok", 32'(i_addr_ok), 32'(tbl[k].e_iaok));
      check("tbl_d_addr_ok", 32'(d_addr_ok), 32'(tbl[k].e_daok));
      tick();
      i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = tbl[k].aok; m_rdata = 32'hA000_0000 + 32'(k);
      tick();
      m_data_ok = 0;
    end
    // reset while waiting for D data
    do_reset();
    d_req = 1; m_addr_ok = 1;
    #1 check("rst_dw_d_accept", 32'(d_addr_ok), 32'd1);
    tick();
    d_req = 0; m_addr_ok = 0;
    #1 check("rst_dw_m_req", 32'(m_req), 32'd0);
    i_req = 1; m_data_ok = 1; rst = 0;
    #1 check("rst_async_outputs", 32'({m_req, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 32'd0);
    tick();
    rst = 1; m_data_ok = 0; m_addr_ok = 1;
    sb.push_back('{1, 32'h1111_2222});
    #1;
    check("rst_first_i_grant", 32'(i_addr_ok), 32'd1);
    check("rst_first_i_addr", m_addr, IA);
    tick();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111_2222;
    tick();
    m_data_ok = 0;
    // single I read with 3-cycle data latency
    do_reset();
    c0 = cnt_iaok; c1 = cnt_idok; c2 = cnt_daok + cnt_ddok;
    i_req = 1; m_addr_ok = 1;
    sb.push_back('{1, 32'h3C08_0001});
    #1 check("iread_m_addr", m_addr, IA);
    tick();
    i_req = 0; m_addr_ok = 0;
    tick();
    tick();
    m_data_ok = 1; m_rdata = 32'h3C08_0001;
    tick();
    m_data_ok = 0;
    tick();
    check("iread_addr_ok_pulses", 32'(cnt_iaok - c0), 32'd1);
    check("iread_data_ok_pulses", 32'(cnt_idok - c1), 32'd1);
    check("iread_d_ok_pulses", 32'(cnt_daok + cnt_ddok - c2), 32'd0);
    // simultaneous requests: D first, I right after D completes
    do_reset();
    i_req = 1; d_req = 1; d_wr = 1; d_wdata = 32'hDEAD_BEEF; i_wr = 0; m_addr_ok = 1;
    sb.push_back('{0, 32'hCAFE_0001});
    sb.push_back('{1, 32'hCAFE_0002});
    #1;
    check("sim_m_addr", m_addr, DA);
    check("sim_m_wr", 32'(m_wr), 32'd1);
    check("sim_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("sim_m_size", 32'(m_size), 32'd2);
    check("sim_oks", 32'({i_addr_ok, d_addr_ok}), 32'd1);
    tick();
    d_req = 0; m_data_ok = 1; m_rdata = 32'hCAFE_0001;
    #1 check("sim_no_overlap", 32'({m_req, i_addr_ok}), 32'd0);
    tick();
    m_data_ok = 0;
    #1;
    check("sim_i_grant", 32'(i_addr_ok), 32'd1);
    check("sim_i_addr", m_addr, IA);
    tick();
    i_req = 0; m_data_ok = 1; m_rdata = 32'hCAFE_0002;
    tick();
    m_data_ok = 0; d_wr = 0;
    // address-phase lock on D while I arrives
    do_reset();
    d_req = 1; m_addr_ok = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) i_req = 1;
      #1;
      check("lock_m_addr", m_addr, DA);
      check("lock_i_addr_ok", 32'(i_addr_ok), 32'd0);
      tick();
    end
    m_addr_ok = 1;
    sb.push_back('{0, 32'hCAFE_0003});
    sb.push_back('{1, 32'hCAFE_0004});
    #1 check("lock_d_accept", 32'(d_addr_ok), 32'd1);
    tick();
    d_req = 0; m_data_ok = 1; m_rdata = 32'hCAFE_0003;
    #1 check("lock_i_wait", 32'(i_addr_ok), 32'd0);
    tick();
    m_data_ok = 0;
    #1 check("lock_i_grant", 32'(i_addr_ok), 32'd1);
    tick();
    i_req = 0; m_data_ok = 1; m_rdata = 32'hCAFE_0004;
    tick();
    m_data_ok = 0;
    // starvation guard: D,D,D,D,I,D,D,D,D,I with both requests held
    do_reset();
    n_resp = 0;
    for (int k = 0; k < 10; k++) begin
      gq.push_back(k == 4 || k == 9);
      sb.push_back('{(k == 4 || k == 9), 32'h1000_0000 + 32'(k)});
    end
    auto_mem = 1; lat = 2; m_addr_ok = 1; i_req = 1; d_req = 1;
    for (int k = 0; k < 300 && (gq.size() != 0 || sb.size() != 0); k++) begin
      tick();
      if (gq.size() == 0) begin i_req = 0; d_req = 0; end
    end
    check("starve_drained", 32'(gq.size() + sb.size()), 32'd0);
    auto_mem = 0; m_data_ok = 0; m_addr_ok = 0;
    // stray data_ok in IDLE
    do_reset();
    m_data_ok = 1;
    #1 check("stray_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
    tick();
    m_data_ok = 0;
    tick();
    check("strict_d_never_i", 32'(cnt_i0), 32'd0);
    check("strict_d_grants", 32'(cnt_d0 > 20), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
